// File: rtl/eth_frame_sequencer.sv
// Frame sequencer ahead of the Ethernet/IP/ITCH parse chain.
// Counts 64-bit beats, strobes the Ethernet and IP header
// decoders, forwards payload, drops bad or runt frames and
// truncates frames longer than MAX_WORDS beats.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   dataIn/inValid/inLast/inReady   frame beat input
//   counter/ethLoad                 Ethernet decoder select/load
//   ipLoad/ipWordIdx                IP decoder load/beat index
//   hdrData                         beat shown to header decoders
//   payData/payValid/payLast/payErr/payReady  payload output
//   frameDrop       one-cycle pulse per discarded frame
//   busy            high whenever not idle
//
// Optional build macro SEQ_STATS_EN adds frameCnt, dropCnt and
// truncCnt statistics outputs.
module eth_frame_sequencer #(
  parameter logic [15:0] ETYPE_IPV4   = 16'h0800,
  parameter int          IP_HDR_WORDS = 3,
  parameter int          MAX_WORDS    = 190,
  parameter int          WCNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] dataIn,
  input  logic        inValid,
  input  logic        inLast,
  output logic        inReady,
  output logic        counter,
  output logic        ethLoad,
  output logic        ipLoad,
  output logic [1:0]  ipWordIdx,
  output logic [63:0] hdrData,
  output logic [63:0] payData,
  output logic        payValid,
  output logic        payLast,
  output logic        payErr,
  input  logic        payReady,
  output logic        frameDrop,
`ifdef SEQ_STATS_EN
  output logic [31:0] frameCnt,
  output logic [31:0] dropCnt,
  output logic [15:0] truncCnt,
`endif
  output logic        busy
);

  // IDLE doubles as ETH0: the first accepted beat is the
  // first Ethernet header beat.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ETH1,
    S_IPHDR,
    S_PAY,
    S_DROP
  } state_t;

  localparam logic [WCNT_W-1:0] MAX_W =
    WCNT_W'(MAX_WORDS);
  localparam logic [WCNT_W-1:0] TRUNC_W =
    WCNT_W'(MAX_WORDS - 1);
  localparam logic [1:0] IP_LAST_W =
    2'(IP_HDR_WORDS - 1);

  state_t state_q, state_d;

  logic [WCNT_W-1:0] wcnt_q, wcnt_d, wcnt_inc;
  logic [1:0]        ipidx_q, ipidx_d;

  logic [63:0] payData_q, payData_d;
  logic        payValid_q, payValid_d;
  logic        payLast_q, payLast_d;
  logic        payErr_q, payErr_d;
  logic        frameDrop_q, frameDrop_d;

  logic acc;
  logic etype_ok;
  logic ip_last;
  logic trunc;
  logic pay_done;

`ifdef SEQ_STATS_EN
  logic [31:0] frameCnt_q, frameCnt_d;
  logic [31:0] dropCnt_q, dropCnt_d;
  logic [15:0] truncCnt_q, truncCnt_d;
`endif

  // Only the payload state can stall: the single output
  // register must be empty or draining this cycle.
  always_comb begin
    inReady = 1'b0;
    if (!rst) begin
      if (state_q == S_PAY) begin
        inReady = !payValid_q || payReady;
      end else begin
        inReady = 1'b1;
      end
    end
  end

  assign acc      = inValid && inReady;
  assign etype_ok = (dataIn[63:48] == ETYPE_IPV4);
  assign ip_last  = (ipidx_q == IP_LAST_W);
  assign pay_done = payValid_q && payReady;

  // Beat number MAX_WORDS without inLast ends the frame early.
  assign trunc = acc && (state_q == S_PAY) && !inLast &&
                 (wcnt_q == TRUNC_W);

  assign wcnt_inc = (wcnt_q == MAX_W) ? wcnt_q
                  : wcnt_q + WCNT_W'(1);

  assign hdrData   = dataIn;
  assign counter   = (state_q == S_ETH1);
  assign ethLoad   = acc && ((state_q == S_IDLE) ||
                             (state_q == S_ETH1));
  assign ipLoad    = acc && (state_q == S_IPHDR);
  assign ipWordIdx = (state_q == S_IPHDR) ? ipidx_q : 2'd0;

  assign payData   = payData_q;
  assign payValid  = payValid_q;
  assign payLast   = payLast_q;
  assign payErr    = payErr_q;
  assign frameDrop = frameDrop_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    ipidx_d     = ipidx_q;
    frameDrop_d = 1'b0;
    payData_d   = payData_q;
    payValid_d  = payValid_q;
    payLast_d   = payLast_q;
    payErr_d    = payErr_q;

    if (pay_done) begin
      payValid_d = 1'b0;
      payLast_d  = 1'b0;
      payErr_d   = 1'b0;
    end

    if (acc) begin
      wcnt_d = wcnt_inc;
      unique case (state_q)
        S_IDLE: begin
          if (inLast) begin
            frameDrop_d = 1'b1;
            wcnt_d      = '0;
          end else begin
            state_d = S_ETH1;
          end
        end
        S_ETH1: begin
          if (inLast) begin
            frameDrop_d = 1'b1;
            state_d     = S_IDLE;
            wcnt_d      = '0;
          end else if (etype_ok) begin
            state_d = S_IPHDR;
            ipidx_d = 2'd0;
          end else begin
            state_d = S_DROP;
          end
        end
        S_IPHDR: begin
          if (inLast) begin
            frameDrop_d = 1'b1;
            state_d     = S_IDLE;
            wcnt_d      = '0;
            ipidx_d     = 2'd0;
          end else if (ip_last) begin
            state_d = S_PAY;
            ipidx_d = 2'd0;
          end else begin
            ipidx_d = ipidx_q + 2'd1;
          end
        end
        S_PAY: begin
          payData_d  = dataIn;
          payValid_d = 1'b1;
          payLast_d  = inLast || trunc;
          payErr_d   = trunc;
          if (inLast) begin
            state_d = S_IDLE;
            wcnt_d  = '0;
          end else if (trunc) begin
            state_d = S_DROP;
          end
        end
        S_DROP: begin
          if (inLast) begin
            frameDrop_d = 1'b1;
            state_d     = S_IDLE;
            wcnt_d      = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          wcnt_d  = '0;
        end
      endcase
    end
  end

`ifdef SEQ_STATS_EN
  always_comb begin
    frameCnt_d = frameCnt_q;
    dropCnt_d  = dropCnt_q;
    truncCnt_d = truncCnt_q;
    if (pay_done && payLast_q) begin
      frameCnt_d = frameCnt_q + 32'd1;
    end
    if (frameDrop_d) begin
      dropCnt_d = dropCnt_q + 32'd1;
    end
    if (trunc) begin
      truncCnt_d = truncCnt_q + 16'd1;
    end
  end

  assign frameCnt = frameCnt_q;
  assign dropCnt  = dropCnt_q;
  assign truncCnt = truncCnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      ipidx_q     <= 2'd0;
      payData_q   <= '0;
      payValid_q  <= 1'b0;
      payLast_q   <= 1'b0;
      payErr_q    <= 1'b0;
      frameDrop_q <= 1'b0;
`ifdef SEQ_STATS_EN
      frameCnt_q  <= '0;
      dropCnt_q   <= '0;
      truncCnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      ipidx_q     <= ipidx_d;
      payData_q   <= payData_d;
      payValid_q  <= payValid_d;
      payLast_q   <= payLast_d;
      payErr_q    <= payErr_d;
      frameDrop_q <= frameDrop_d;
`ifdef SEQ_STATS_EN
      frameCnt_q  <= frameCnt_d;
      dropCnt_q   <= dropCnt_d;
      truncCnt_q  <= truncCnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_eth_frame_sequencer.sv
// Bench for eth_frame_sequencer: frame-level reference model
// checked every cycle, plus directed literal expectations.
module tb_eth_frame_sequencer;

  localparam int MAXW = 8;
  localparam int HDRW = 5;

  logic        clk;
  logic        rst;
  logic [63:0] dataIn;
  logic        inValid;
  logic        inLast;
  logic        inReady;
  logic        counter;
  logic        ethLoad;
  logic        ipLoad;
  logic [1:0]  ipWordIdx;
  logic [63:0] hdrData;
  logic [63:0] payData;
  logic        payValid;
  logic        payLast;
  logic        payErr;
  logic        payReady;
  logic        frameDrop;
  logic        busy;
`ifdef SEQ_STATS_EN
  logic [31:0] frameCnt;
  logic [31:0] dropCnt;
  logic [15:0] truncCnt;
`endif

  eth_frame_sequencer #(
    .ETYPE_IPV4  (16'h0800),
    .IP_HDR_WORDS(3),
    .MAX_WORDS   (MAXW),
    .WCNT_W      (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dataIn   (dataIn),
    .inValid  (inValid),
    .inLast   (inLast),
    .inReady  (inReady),
    .counter  (counter),
    .ethLoad  (ethLoad),
    .ipLoad   (ipLoad),
    .ipWordIdx(ipWordIdx),
    .hdrData  (hdrData),
    .payData  (payData),
    .payValid (payValid),
    .payLast  (payLast),
    .payErr   (payErr),
    .payReady (payReady),
    .frameDrop(frameDrop),
`ifdef SEQ_STATS_EN
    .frameCnt (frameCnt),
    .dropCnt  (dropCnt),
    .truncCnt (truncCnt),
`endif
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [63:0] d;
    logic        l;
    logic        e;
  } pay_t;

  pay_t q[$];
  pay_t e;
  int   pos;
  int   k;
  bit   ok;
  bit   drop_pend;
  bit   lat_pend;
  bit   hold_pend;
  bit   m_acc;
  bit   exp_eth;
  bit   exp_ip;
  bit   pay_phase;
  logic [63:0] lat_data;
  logic [63:0] hold_data;

  int eth_seen, ip_seen, pay_seen;
  int drop_seen, err_seen, rdy_low;
  logic [63:0] last_pay;

  // Frame model: position within the frame decides the role
  // of each accepted beat; payload items are queued in order.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      pos       = 0;
      ok        = 1'b0;
      drop_pend = 1'b0;
      lat_pend  = 1'b0;
      hold_pend = 1'b0;
    end else begin
      check("frameDrop", frameDrop, drop_pend);
      drop_pend = 1'b0;
      if (frameDrop) drop_seen++;
      check("busy", busy, pos != 0);

      if (lat_pend) begin
        check("pay_lat_valid", payValid, 1);
        check("pay_lat_data", payData, lat_data);
        lat_pend = 1'b0;
      end
      if (hold_pend) begin
        check("pay_hold_valid", payValid, 1);
        check("pay_hold_data", payData, hold_data);
      end
      hold_pend = payValid && !payReady;
      hold_data = payData;

      if (payValid && payReady) begin
        pay_seen++;
        last_pay = payData;
        if (payErr) err_seen++;
        if (q.size() == 0) begin
          check("pay_unexpected", payValid, 0);
        end else begin
          e = q.pop_front();
          check("pay_data", payData, e.d);
          check("pay_last", payLast, e.l);
          check("pay_err", payErr, e.e);
        end
      end

      pay_phase = ok && pos >= HDRW && pos < MAXW;
      check("inReady", inReady,
            pay_phase ? (!payValid || payReady) : 1'b1);
      if (!inReady) rdy_low++;

      m_acc   = inValid && inReady;
      k       = pos + 1;
      exp_eth = m_acc && k <= 2;
      exp_ip  = m_acc && ok && k >= 3 && k <= HDRW;
      check("ethLoad", ethLoad, exp_eth);
      check("ipLoad", ipLoad, exp_ip);
      if (exp_eth) check("counter", counter, k == 2);
      if (exp_ip) check("ipWordIdx", ipWordIdx, 64'(k - 3));
      if (ethLoad) eth_seen++;
      if (ipLoad) ip_seen++;
      if (m_acc && k <= HDRW) check("hdrData", hdrData, dataIn);

      if (m_acc) begin
        if (k == 1) ok = 1'b0;
        if (k == 2) ok = (dataIn[63:48] == 16'h0800);
        if (ok && k > HDRW && k <= MAXW) begin
          q.push_back({dataIn, inLast || k == MAXW,
                       k == MAXW && !inLast});
          lat_pend = 1'b1;
          lat_data = dataIn;
        end
        if (inLast) begin
          if (k <= HDRW || !ok || k > MAXW) drop_pend = 1'b1;
          pos = 0;
        end else begin
          pos = k;
        end
      end
    end
  end

  function automatic logic [63:0] beat(input logic [7:0] id,
                                       input int kk,
                                       input logic [15:0] et);
    if (kk == 2) return {et, 16'h00AA, 24'h0, id};
    return {id, 8'(kk), 48'h0000_1234_5678};
  endfunction

  task automatic drive_beat(input logic [63:0] d,
                            input logic l);
    dataIn  = d;
    inLast  = l;
    inValid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (inReady) break;
    end
    check("beat_accept", inReady, 1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] id,
                            input int n,
                            input logic [15:0] et);
    for (int i = 1; i <= n; i++) begin
      drive_beat(beat(id, i, et), i == n);
    end
  endtask

  task automatic send_partial(input logic [7:0] id,
                              input int n);
    for (int i = 1; i <= n; i++) begin
      drive_beat(beat(id, i, 16'h0800), 1'b0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_seen();
    eth_seen  = 0;
    ip_seen   = 0;
    pay_seen  = 0;
    drop_seen = 0;
    err_seen  = 0;
    rdy_low   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    inValid  = 1'b0;
    inLast   = 1'b0;
    dataIn   = '0;
    payReady = 1'b1;
    clr_seen();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_payValid", payValid, 0);
    check("rst_payLast", payLast, 0);
    check("rst_payErr", payErr, 0);
    check("rst_payData", payData, 0);
    check("rst_frameDrop", frameDrop, 0);
    check("rst_inReady", inReady, 0);
    check("rst_ethLoad", ethLoad, 0);
    check("rst_ipLoad", ipLoad, 0);
    check("rst_counter", counter, 0);
    check("rst_ipWordIdx", ipWordIdx, 0);
`ifdef SEQ_STATS_EN
    check("rst_frameCnt", frameCnt, 0);
    check("rst_dropCnt", dropCnt, 0);
    check("rst_truncCnt", truncCnt, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // valid 6-beat IPv4 frame
    clr_seen();
    send_frame(8'h01, 6, 16'h0800);
    idle(3);
    check("t1_eth_cnt", eth_seen, 2);
    check("t1_ip_cnt", ip_seen, 3);
    check("t1_pay_cnt", pay_seen, 1);
    check("t1_drop_cnt", drop_seen, 0);
    check("t1_pay_data", last_pay, 64'h0106_0000_1234_5678);

    // non-IPv4 EtherType, 10 beats
    clr_seen();
    send_frame(8'h02, 10, 16'h86DD);
    idle(3);
    check("t2_eth_cnt", eth_seen, 2);
    check("t2_ip_cnt", ip_seen, 0);
    check("t2_pay_cnt", pay_seen, 0);
    check("t2_drop_cnt", drop_seen, 1);

    // runt ending at IP beat 0, next frame back to back
    clr_seen();
    send_frame(8'h03, 3, 16'h0800);
    send_frame(8'h13, 6, 16'h0800);
    idle(3);
    check("t3_ip_cnt", ip_seen, 4);
    check("t3_pay_cnt", pay_seen, 1);
    check("t3_drop_cnt", drop_seen, 1);
    check("t3_pay_data", last_pay, 64'h1306_0000_1234_5678);

    // payload backpressure for 3 cycles
    clr_seen();
    fork
      send_frame(8'h04, 8, 16'h0800);
      begin
        repeat (7) @(posedge clk);
        #1 payReady = 1'b0;
        repeat (3) @(posedge clk);
        #1 payReady = 1'b1;
      end
    join
    idle(3);
    check("t4_pay_cnt", pay_seen, 3);
    check("t4_rdy_low", rdy_low, 3);
    check("t4_drop_cnt", drop_seen, 0);
    check("t4_pay_data", last_pay, 64'h0408_0000_1234_5678);

    // 12-beat frame truncated at beat 8, then a normal frame
    clr_seen();
    send_frame(8'h05, 12, 16'h0800);
    send_frame(8'h06, 6, 16'h0800);
    idle(3);
    check("t5_pay_cnt", pay_seen, 4);
    check("t5_err_cnt", err_seen, 1);
    check("t5_drop_cnt", drop_seen, 1);
    check("t5_pay_data", last_pay, 64'h0606_0000_1234_5678);
`ifdef SEQ_STATS_EN
    check("st_frameCnt", frameCnt, 5);
    check("st_dropCnt", dropCnt, 3);
    check("st_truncCnt", truncCnt, 1);
`endif

    // reset while in payload
    send_partial(8'h07, 6);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_busy", busy, 0);
    check("t6_payValid", payValid, 0);
    check("t6_frameDrop", frameDrop, 0);
`ifdef SEQ_STATS_EN
    check("t6_frameCnt", frameCnt, 0);
    check("t6_dropCnt", dropCnt, 0);
    check("t6_truncCnt", truncCnt, 0);
`endif
    rst = 1'b0;
    clr_seen();
    idle(2);
    send_frame(8'h08, 6, 16'h0800);
    idle(3);
    check("t6_pay_cnt", pay_seen, 1);
    check("t6_drop_cnt", drop_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
